// File: rtl/cam_pkg.sv
// Shared constants, FSM encoding and colour reduction for the camera capture path.
package cam_pkg;

  localparam int unsigned H_PIXELS     = 640;
  localparam int unsigned V_LINES      = 480;
  localparam int unsigned FRAME_PIXELS = H_PIXELS * V_LINES;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_VS_HI = 2'd1;
  localparam logic [1:0] ST_WAIT_VS_LO = 2'd2;
  localparam logic [1:0] ST_CAPTURE    = 2'd3;

  // {R5,G6,B5} -> {R5[4:1], G6[5:2], B5[4:1]}
  function automatic logic [11:0] rgb565_to_rgb444(input logic [15:0] p);
    return {p[15:12], p[10:7], p[4:1]};
  endfunction

endpackage

// File: rtl/cam_byte_pair.sv
// Pairs camera bytes into RGB565 pixels and reduces them to RGB444.
//   clk, reset   : pixel clock, synchronous active-high reset
//   clear        : force byte phase back to 0 (line end / not capturing)
//   byte_valid   : din carries an active byte this cycle
//   din          : registered camera byte
//   pix_valid_c  : combinational strobe, a full pixel is available this cycle
//   pix444_c     : combinational {R4,G4,B4} of the pixel being completed
module cam_byte_pair
  import cam_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  din,
  output logic        pix_valid_c,
  output logic [11:0] pix444_c
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  // Phase 0 latches the high byte, phase 1 completes the pixel.
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    if (clear) begin
      phase_d = 1'b0;
    end else if (byte_valid) begin
      if (!phase_q) hi_d = din;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      hi_q    <= 8'd0;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  assign pix_valid_c = byte_valid & phase_q & ~clear;
  assign pix444_c    = rgb565_to_rgb444({hi_q, din});

endmodule

// File: rtl/camera_capture.sv
// Captures one RGB565 camera frame (or a continuous stream) into frame_buffer port A.
//   clk, reset            : camera pixel clock, synchronous active-high reset
//   arm                   : 1-cycle request to capture the next full frame
//   continuous            : re-arm after each frame (sampled at frame end)
//   cam_vsync/href/din    : raw camera PMOD signals
//   pixel_data/write_addr/write_enable : frame_buffer port A write
//   busy, frame_done, err : status; err = {overflow, short_frame}, sticky until next arm
module camera_capture #(
  parameter int unsigned H_PIXELS = 640,
  parameter int unsigned V_LINES  = 480,
  parameter int unsigned ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              continuous,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_din,
  output logic [11:0]       pixel_data,
  output logic [ADDR_W-1:0] write_addr,
  output logic              write_enable,
  output logic              busy,
  output logic              frame_done,
  output logic [1:0]        err
);
  import cam_pkg::*;

  localparam int unsigned LAST_ADDR = H_PIXELS * V_LINES - 1;

  logic              vsync_q, vsync_d, vsync_prev_q, vsync_prev_d;
  logic              href_q, href_d, href_prev_q, href_prev_d;
  logic [7:0]        din_q, din_d;
  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              full_q, full_d;
  logic [11:0]       pixel_data_q, pixel_data_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic              write_enable_q, write_enable_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic [1:0]        err_q, err_d;

  logic        vs_rise_c, vs_fall_c, href_fall_c, in_capture_c;
  logic        byte_valid_c, clear_c, pix_valid_c;
  logic [11:0] pix444_c;

  // Input stage and one-cycle history for edge detection.
  always_comb begin
    vsync_d      = cam_vsync;
    href_d       = cam_href;
    din_d        = cam_din;
    vsync_prev_d = vsync_q;
    href_prev_d  = href_q;
  end

  assign vs_rise_c    = vsync_q & ~vsync_prev_q;
  assign vs_fall_c    = ~vsync_q & vsync_prev_q;
  assign href_fall_c  = ~href_q & href_prev_q;
  assign in_capture_c = (state_q == ST_CAPTURE);
  // A byte coinciding with frame end is not part of the frame.
  assign byte_valid_c = in_capture_c & href_q & ~vs_rise_c;
  assign clear_c      = ~in_capture_c | href_fall_c;

  cam_byte_pair u_byte_pair (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear_c),
    .byte_valid  (byte_valid_c),
    .din         (din_q),
    .pix_valid_c (pix_valid_c),
    .pix444_c    (pix444_c)
  );

  // Next-state, address counter, status and write port.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    full_d         = full_q;
    err_d          = err_q;
    busy_d         = busy_q;
    pixel_data_d   = pixel_data_q;
    write_addr_d   = write_addr_q;
    write_enable_d = 1'b0;
    frame_done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_WAIT_VS_HI;
          err_d   = 2'b00;
          addr_d  = '0;
          full_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ST_WAIT_VS_HI: begin
        if (vs_rise_c) state_d = ST_WAIT_VS_LO;
      end
      ST_WAIT_VS_LO: begin
        if (vs_fall_c) begin
          state_d = ST_CAPTURE;
          addr_d  = '0;
          full_d  = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (pix_valid_c) begin
          // full_q marks that the last legal address has been written.
          if (full_q) begin
            err_d[1] = 1'b1;
          end else begin
            write_enable_d = 1'b1;
            pixel_data_d   = pix444_c;
            write_addr_d   = addr_q;
            if (addr_q == ADDR_W'(LAST_ADDR)) full_d = 1'b1;
            else                               addr_d = addr_q + ADDR_W'(1);
          end
        end
        if (vs_rise_c) begin
          frame_done_d = 1'b1;
          if (!full_q) err_d[0] = 1'b1;
          if (continuous) begin
            state_d = ST_WAIT_VS_LO;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q        <= 1'b0;
      vsync_prev_q   <= 1'b0;
      href_q         <= 1'b0;
      href_prev_q    <= 1'b0;
      din_q          <= 8'd0;
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      full_q         <= 1'b0;
      pixel_data_q   <= 12'd0;
      write_addr_q   <= '0;
      write_enable_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      err_q          <= 2'b00;
    end else begin
      vsync_q        <= vsync_d;
      vsync_prev_q   <= vsync_prev_d;
      href_q         <= href_d;
      href_prev_q    <= href_prev_d;
      din_q          <= din_d;
      state_q        <= state_d;
      addr_q         <= addr_d;
      full_q         <= full_d;
      pixel_data_q   <= pixel_data_d;
      write_addr_q   <= write_addr_d;
      write_enable_q <= write_enable_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      err_q          <= err_d;
    end
  end

  assign pixel_data   = pixel_data_q;
  assign write_addr   = write_addr_q;
  assign write_enable = write_enable_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture on a reduced 8x6 frame.
module tb_camera_capture;

  localparam int H     = 8;
  localparam int V     = 6;
  localparam int AW    = 6;
  localparam int FRAME = H * V;

  logic          clk = 1'b0;
  logic          reset, arm, continuous, cam_vsync, cam_href;
  logic [7:0]    cam_din;
  logic [11:0]   pixel_data;
  logic [AW-1:0] write_addr;
  logic          write_enable, busy, frame_done;
  logic [1:0]    err;

  camera_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .arm(arm), .continuous(continuous),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_din(cam_din),
    .pixel_data(pixel_data), .write_addr(write_addr), .write_enable(write_enable),
    .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [11:0]   data;
    int            cyc;
  } wr_t;

  wr_t        wq[$];
  logic [1:0] dq[$];
  logic [1:0] m_err;

  int n_chk = 0, n_pass = 0;
  int n_wr = 0, n_done = 0;
  logic [AW-1:0] last_addr;
  logic [11:0]   last_data;
  logic [11:0]   seen [0:FRAME-1];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // RGB565 byte pair to RGB444 from the colour field definitions.
  function automatic logic [11:0] conv(input logic [7:0] hi, input logic [7:0] lo);
    logic [4:0] r; logic [5:0] g; logic [4:0] b;
    r = hi[7:3];
    g = {hi[2:0], lo[7:5]};
    b = lo[4:0];
    return {r[4:1], g[5:2], b[4:1]};
  endfunction

  function automatic logic [7:0] pat_byte(input int mode, input int l, input int b);
    if (mode == 0) return (b % 2 == 0) ? 8'hF8 : 8'h00;
    if (l == 3 && b == 10) return 8'h07;
    if (l == 3 && b == 11) return 8'hE0;
    return 8'((l * 37 + b * 11 + mode * 13) ^ (b * 5));
  endfunction

  // Every write and frame end is checked against the queued expectations.
  always @(negedge clk) begin
    if (write_enable) begin
      n_wr++;
      last_addr = write_addr;
      last_data = pixel_data;
      if (int'(write_addr) < FRAME) seen[int'(write_addr)] = pixel_data;
      if (wq.size() == 0) chk("unexpected_write", 1, 0);
      else begin
        wr_t e;
        e = wq.pop_front();
        chk("wr_addr", int'(write_addr), int'(e.addr));
        chk("wr_data", int'(pixel_data), int'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (frame_done) begin
      n_done++;
      if (dq.size() == 0) chk("unexpected_frame_done", 1, 0);
      else chk("done_err", int'(err), int'(dq.pop_front()));
    end
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_arm();
    arm = 1'b1; idle(1); arm = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pixel_data"}, int'(pixel_data), 0);
    chk({tag, "_write_addr"}, int'(write_addr), 0);
    chk({tag, "_write_enable"}, int'(write_enable), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
    chk({tag, "_err"}, int'(err), 0);
  endtask

  // Accepted arm followed by a vsync rise, leaving vsync high.
  task automatic arm_and_sync();
    pulse_arm();
    m_err = 2'b00;
    cam_vsync = 1'b0; idle(3);
    cam_vsync = 1'b1; idle(3);
  endtask

  // One frame: vsync falls, lines of href bytes, vsync rises (frame end).
  task automatic frame(input int nlines, input int odd_line, input bit cap,
                       input int mode, input int arm_line, input int rst_line);
    int cnt; bit ovf; bit capl; int nb; logic [7:0] hi; logic [7:0] by;
    cnt = 0; ovf = 0; capl = cap; hi = 8'd0;
    cam_vsync = 1'b0; idle(3);
    for (int l = 0; l < nlines; l++) begin
      if (l == arm_line) begin pulse_arm(); idle(1); end
      if (l == rst_line) begin
        reset = 1'b1; idle(1); reset = 1'b0;
        check_zero("midframe_reset");
        capl = 0;
        idle(1);
      end
      nb = (l == odd_line) ? 2 * H + 1 : 2 * H;
      for (int b = 0; b < nb; b++) begin
        by = pat_byte(mode, l, b);
        cam_href = 1'b1; cam_din = by;
        if (b % 2 == 0) hi = by;
        else if (capl) begin
          if (cnt < FRAME) begin
            wq.push_back('{addr: AW'(cnt), data: conv(hi, by), cyc: cyc + 2});
            cnt++;
          end else ovf = 1;
        end
        idle(1);
      end
      cam_href = 1'b0; cam_din = 8'd0; idle(3);
    end
    cam_vsync = 1'b1;
    if (capl) begin
      m_err = m_err | {ovf, (cnt < FRAME) ? 1'b1 : 1'b0};
      dq.push_back(m_err);
    end
    idle(4);
  endtask

  initial begin
    int w0, d0;
    reset = 1'b1; arm = 0; continuous = 0; cam_vsync = 0; cam_href = 0; cam_din = 0;
    m_err = 2'b00;
    idle(3);
    check_zero("reset");
    reset = 1'b0; idle(2);

    // 1: full frame of 0xF8,0x00; an arm during capture is ignored.
    w0 = n_wr; d0 = n_done;
    arm_and_sync();
    chk("t1_busy_after_arm", int'(busy), 1);
    frame(V, -1, 1, 0, 2, -1);
    chk("t1_write_count", n_wr - w0, 48);
    chk("t1_last_addr", int'(last_addr), 47);
    chk("t1_last_data", int'(last_data), 12'hF00);
    chk("t1_done_count", n_done - d0, 1);
    chk("t1_err", int'(err), 0);
    chk("t1_busy_end", int'(busy), 0);

    // 2: 0x07,0xE0 at line 3 pixel 5 lands at 3*8+5.
    arm_and_sync();
    frame(V, -1, 1, 1, -1, -1);
    chk("t2_addr29_data", int'(seen[29]), 12'h0F0);

    // 3: arm during a frame -> capture begins with the following frame.
    w0 = n_wr;
    m_err = 2'b00;
    frame(V, -1, 0, 2, 2, -1);
    chk("t3_no_writes_partial", n_wr - w0, 0);
    chk("t3_busy_waiting", int'(busy), 1);
    frame(V, -1, 1, 2, -1, -1);

    // 4: one line too many -> overflow only.
    w0 = n_wr;
    arm_and_sync();
    frame(V + 1, -1, 1, 3, -1, -1);
    chk("t4_write_count", n_wr - w0, 48);
    chk("t4_last_addr", int'(last_addr), 47);
    chk("t4_err", int'(err), 2'b10);

    // 5: short frame in continuous mode, then a full frame keeping err.
    continuous = 1'b1;
    arm_and_sync();
    chk("t5_err_cleared_by_arm", int'(err), 0);
    frame(V - 1, -1, 1, 4, -1, -1);
    chk("t5_err_short", int'(err), 2'b01);
    chk("t5_busy_rearmed", int'(busy), 1);
    continuous = 1'b0;
    frame(V, -1, 1, 5, 2, -1);
    chk("t5_err_sticky", int'(err), 2'b01);
    chk("t5_busy_end", int'(busy), 0);

    // 6: reset at line 3; nothing more is written without a new arm.
    w0 = n_wr; d0 = n_done;
    arm_and_sync();
    frame(V, -1, 1, 6, -1, 3);
    frame(V, -1, 0, 6, -1, -1);
    chk("t6_write_count", n_wr - w0, 24);
    chk("t6_no_done", n_done - d0, 0);

    // 7: line 2 carries 2H+1 bytes.
    w0 = n_wr;
    arm_and_sync();
    frame(V, 2, 1, 7, -1, -1);
    chk("t7_write_count", n_wr - w0, 48);

    // 8: vsync rise seen in the same cycle as arm is not counted.
    cam_vsync = 1'b0; idle(3);
    cam_vsync = 1'b1; idle(1);
    pulse_arm();
    m_err = 2'b00;
    idle(2);
    w0 = n_wr;
    frame(V, -1, 0, 8, -1, -1);
    chk("t8_no_writes_first", n_wr - w0, 0);
    frame(V, -1, 1, 9, -1, -1);
    chk("t8_write_count", n_wr - w0, 48);

    idle(5);
    chk("writes_outstanding", wq.size(), 0);
    chk("frame_done_outstanding", dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
